// File: rtl/stream_pipe_pkg.sv
// Shared types for the multi-lane valid/ready retiming pipe.
// Stage styles and the states of the two-entry skid stage.
package stream_pipe_pkg;

    typedef enum logic {
        PM_SLICE = 1'b0,
        PM_SKID  = 1'b1
    } pipe_mode_e;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_TWO   = 2'd2
    } skid_state_e;

    // Number of words a skid stage holds in a given state.
    function automatic logic [1:0] held_words(input skid_state_e s);
        case (s)
            SK_ONE:  return 2'd1;
            SK_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stream_skid_stage.sv
// One retiming stage of stream_skid_pipe: either a forward register slice
// (MODE 0, one entry) or a full skid buffer (MODE 1, two entries).
module stream_skid_stage
    import stream_pipe_pkg::*;
#(
    parameter int MODE = 1,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data,
    output logic [1:0]    count
);

    generate
        case (MODE)
            PM_SLICE: begin : gen_slice
                logic          full;
                logic [DW-1:0] data;

                // Ready ripples straight back from downstream when the slot is occupied.
                assign up_ready = !full || dn_ready;
                assign dn_valid = full;
                assign dn_data  = data;
                assign count    = {1'b0, full};

                // NOTE: data registers are reset too, so the output word reads zero
                // after reset instead of whatever was in flight.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        full <= 1'b0;
                        data <= '0;
                    end else if (up_ready) begin
                        full <= up_valid;
                        if (up_valid) begin
                            data <= up_data;
                        end
                    end
                end
            end

            PM_SKID: begin : gen_skid
                skid_state_e   state;
                logic [DW-1:0] main_q;
                logic [DW-1:0] skid_q;
                logic          ready_q;
                logic          push;
                logic          pop;

                assign up_ready = ready_q;
                assign dn_valid = (state != SK_EMPTY);
                assign dn_data  = main_q;
                assign count    = held_words(state);
                assign push     = up_valid && ready_q;
                assign pop      = dn_valid && dn_ready;

                // ready_q is the registered image of "next state is not TWO", which
                // keeps out_ready off the upstream ready path entirely.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        state   <= SK_EMPTY;
                        main_q  <= '0;
                        skid_q  <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        case (state)
                            SK_EMPTY: begin
                                if (push) begin
                                    main_q <= up_data;
                                    state  <= SK_ONE;
                                end
                            end
                            SK_ONE: begin
                                if (push && pop) begin
                                    main_q <= up_data;
                                end else if (push) begin
                                    skid_q  <= up_data;
                                    state   <= SK_TWO;
                                    ready_q <= 1'b0;
                                end else if (pop) begin
                                    state <= SK_EMPTY;
                                end
                            end
                            SK_TWO: begin
                                // Skid word moves to the main entry before anything new is taken.
                                if (pop) begin
                                    main_q  <= skid_q;
                                    state   <= SK_ONE;
                                    ready_q <= 1'b1;
                                end
                            end
                            default: begin
                                state   <= SK_EMPTY;
                                ready_q <= 1'b1;
                            end
                        endcase
                    end
                end
            end

            default: begin : gen_bad_mode
                $error("stream_skid_stage: unsupported MODE %0d", MODE);
                assign up_ready = 1'b0;
                assign dn_valid = 1'b0;
                assign dn_data  = '0;
                assign count    = 2'd0;
            end
        endcase
    endgenerate

endmodule

// File: rtl/stream_skid_pipe.sv
// Multi-lane valid/ready retiming pipe of STAGES stages of style MODE.
// Optional per-lane even parity with a sticky error flag: STREAM_SKID_PIPE_PARITY_EN.
module stream_skid_pipe
    import stream_pipe_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int MODE   = 1,
    localparam int OCC_W = (STAGES == 0) ? 1 : $clog2(2 * STAGES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [OCC_W-1:0]       occupancy
`ifdef STREAM_SKID_PIPE_PARITY_EN
    ,
    output logic                   parity_err
`endif
);

    localparam int DATA_W = LANES * WIDTH;
`ifdef STREAM_SKID_PIPE_PARITY_EN
    localparam int SW = DATA_W + LANES;
`else
    localparam int SW = DATA_W;
`endif

    logic [SW-1:0] in_word;
    logic [SW-1:0] out_word;

    assign out_data = out_word[DATA_W-1:0];

`ifdef STREAM_SKID_PIPE_PARITY_EN
    logic [LANES-1:0] in_par;
    logic [LANES-1:0] out_par;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it holding an old value (a latch).
    always_comb begin
        in_par  = '0;
        out_par = '0;
        for (int l = 0; l < LANES; l++) begin
            in_par[l]  = ^in_data[l*WIDTH +: WIDTH];
            out_par[l] = ^out_data[l*WIDTH +: WIDTH];
        end
    end

    assign in_word = {in_par, in_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (out_valid && out_ready && (out_par != out_word[SW-1:DATA_W])) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign in_word = in_data;
`endif

    generate
        if (STAGES == 0) begin : gen_bypass
            // A passthrough has no state, so clock and reset go nowhere.
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk, rst_n};

            assign out_valid = in_valid;
            assign in_ready  = out_ready;
            assign out_word  = in_word;
            assign occupancy = '0;
        end else begin : gen_pipe
            logic          valid_c [STAGES+1];
            logic          ready_c [STAGES+1];
            logic [SW-1:0] data_c  [STAGES+1];
            logic [1:0]    cnt     [STAGES];

            assign valid_c[0]      = in_valid;
            assign in_ready        = ready_c[0];
            assign data_c[0]       = in_word;
            assign out_valid       = valid_c[STAGES];
            assign ready_c[STAGES] = out_ready;
            assign out_word        = data_c[STAGES];

            for (genvar i = 0; i < STAGES; i++) begin : gen_stage
                stream_skid_stage #(
                    .MODE (MODE),
                    .DW   (SW)
                ) u_stage (
                    .clk      (clk),
                    .rst_n    (rst_n),
                    .up_valid (valid_c[i]),
                    .up_ready (ready_c[i]),
                    .up_data  (data_c[i]),
                    .dn_valid (valid_c[i+1]),
                    .dn_ready (ready_c[i+1]),
                    .dn_data  (data_c[i+1]),
                    .count    (cnt[i])
                );
            end

            always_comb begin
                occupancy = '0;
                for (int i = 0; i < STAGES; i++) begin
                    occupancy = occupancy + OCC_W'(cnt[i]);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_stream_skid_pipe.sv
// Scoreboard bench for stream_skid_pipe: a skid pipe (MODE 1, 2 stages), a slice
// pipe (MODE 0, 3 stages) and a passthrough (0 stages) against a queue model.
module tb_stream_skid_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [2:0]  a_occ;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [2:0]  b_occ;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [31:0] c_in_data, c_out_data;
    logic [0:0]  c_occ;
`ifdef STREAM_SKID_PIPE_PARITY_EN
    logic        a_perr, b_perr, c_perr;
`endif

    stream_skid_pipe #(.LANES(4), .WIDTH(8), .STAGES(2), .MODE(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
`ifdef STREAM_SKID_PIPE_PARITY_EN
        , .parity_err(a_perr)
`endif
    );

    stream_skid_pipe #(.LANES(4), .WIDTH(8), .STAGES(3), .MODE(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
`ifdef STREAM_SKID_PIPE_PARITY_EN
        , .parity_err(b_perr)
`endif
    );

    stream_skid_pipe #(.LANES(4), .WIDTH(8), .STAGES(0), .MODE(1)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ)
`ifdef STREAM_SKID_PIPE_PARITY_EN
        , .parity_err(c_perr)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted words in order, and words in flight = accepted - delivered.
    logic [31:0] a_q[$];
    logic [31:0] b_q[$];
    logic [31:0] a_exp, b_exp;
    int          a_occ_m = 0;
    int          b_occ_m = 0;
    int          a_out_cnt = 0;
    int          b_out_cnt = 0;
    bit          sb_hold = 1'b0;

    always @(negedge clk) begin : mon_a_in
        if (rst_n && a_in_valid && a_in_ready) a_q.push_back(a_in_data);
    end

    always @(negedge clk) begin : mon_b_in
        if (rst_n && b_in_valid && b_in_ready) b_q.push_back(b_in_data);
    end

    always @(negedge clk) begin : mon_a_out
        if (!rst_n) begin
            a_q.delete();
            a_occ_m = 0;
        end else begin
            check("a_occupancy", 64'(a_occ), 64'(a_occ_m));
            if (a_out_valid && a_out_ready) begin
                a_out_cnt++;
                if (a_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL a_extra_word: got %0h, expected no word (t=%0t)", a_out_data, $time);
                end else begin
                    a_exp = a_q.pop_front();
                    if (!sb_hold) check("a_data", 64'(a_out_data), 64'(a_exp));
                end
            end
            a_occ_m = a_occ_m + ((a_in_valid && a_in_ready) ? 1 : 0)
                              - ((a_out_valid && a_out_ready) ? 1 : 0);
        end
    end

    always @(negedge clk) begin : mon_b_out
        if (!rst_n) begin
            b_q.delete();
            b_occ_m = 0;
        end else begin
            check("b_occupancy", 64'(b_occ), 64'(b_occ_m));
            // A slice chain accepts whenever downstream is ready or any slot is free.
            check("b_in_ready", 64'(b_in_ready), 64'(b_out_ready || (b_occ_m < 3)));
            if (b_out_valid && b_out_ready) begin
                b_out_cnt++;
                if (b_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL b_extra_word: got %0h, expected no word (t=%0t)", b_out_data, $time);
                end else begin
                    b_exp = b_q.pop_front();
                    check("b_data", 64'(b_out_data), 64'(b_exp));
                end
            end
            b_occ_m = b_occ_m + ((b_in_valid && b_in_ready) ? 1 : 0)
                              - ((b_out_valid && b_out_ready) ? 1 : 0);
        end
    end

    initial begin : watchdog
        #400000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int  n_acc, sent, cyc, base_cnt;
        bit  acc;

        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;

        repeat (2) tick();
        check("rst_a_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_a_out_data",  64'(a_out_data),  64'(0));
        check("rst_a_in_ready",  64'(a_in_ready),  64'(1));
        check("rst_a_occ",       64'(a_occ),       64'(0));
        check("rst_b_out_valid", 64'(b_out_valid), 64'(0));
        check("rst_b_in_ready",  64'(b_in_ready),  64'(1));
        rst_n = 1'b1;
        tick();

        // Latency from empty: word visible after STAGES edges, occupancy 1, 2, 1.
        a_in_valid = 1'b1;
        a_in_data  = 32'h04030201;
        tick();
        check("lat_occ_1",   64'(a_occ),       64'(1));
        check("lat_valid_1", 64'(a_out_valid), 64'(0));
        tick();
        a_in_valid = 1'b0;
        check("lat_occ_2",   64'(a_occ),       64'(2));
        check("lat_valid_2", 64'(a_out_valid), 64'(1));
        check("lat_data_2",  64'(a_out_data),  64'(32'h04030201));
        tick();
        check("lat_occ_3",   64'(a_occ),       64'(1));
        repeat (3) tick();

        // Backpressure on the skid pipe: exactly 2 words per stage get absorbed.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'd1;
        n_acc = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            tick();
            if (acc) begin
                n_acc++;
                a_in_data = a_in_data + 32'd1;
            end
        end
        a_in_valid = 1'b0;
        check("bp_accepted", 64'(n_acc),      64'(4));
        check("bp_in_ready", 64'(a_in_ready), 64'(0));
        check("bp_occ",      64'(a_occ),      64'(4));
        a_out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("bp_drain_valid", 64'(a_out_valid), 64'(1));
            check("bp_drain_data",  64'(a_out_data),  64'(k));
        end
        @(negedge clk);
        check("bp_drain_done", 64'(a_out_valid), 64'(0));
        tick();

        // Slice pipe: 1000 random words under 50% random backpressure.
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_in_data   = $urandom;
            b_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = b_in_valid && b_in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        cyc = 0;
        while (b_q.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("b_sent",      64'(sent),       64'(1000));
        check("b_delivered", 64'(b_out_cnt),  64'(sent));
        check("b_q_empty",   64'(b_q.size()), 64'(0));

        // Passthrough: everything combinational, nothing held.
        for (int k = 0; k < 20; k++) begin
            c_in_valid  = 1'($urandom_range(0, 1));
            c_out_ready = 1'($urandom_range(0, 1));
            c_in_data   = $urandom;
            #1;
            check("c_out_data",  64'(c_out_data),  64'(c_in_data));
            check("c_out_valid", 64'(c_out_valid), 64'(c_in_valid));
            check("c_in_ready",  64'(c_in_ready),  64'(c_out_ready));
            check("c_occ",       64'(c_occ),       64'(0));
            tick();
        end

        // Skid pipe under random traffic on both sides.
        base_cnt = a_out_cnt;
        sent = 0;
        cyc  = 0;
        while (sent < 300 && cyc < 10000) begin
            a_in_valid  = 1'($urandom_range(0, 1));
            a_in_data   = $urandom;
            a_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            tick();
            if (acc) sent++;
            cyc++;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        cyc = 0;
        while (a_q.size() != 0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("a_sent",      64'(sent),                 64'(300));
        check("a_delivered", 64'(a_out_cnt - base_cnt), 64'(sent));

        // Asynchronous reset with three words in flight.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_in_data = 32'h11 * (k + 1);
            tick();
        end
        a_in_valid = 1'b0;
        check("mid_occ_before", 64'(a_occ), 64'(3));
        #2 rst_n = 1'b0;
        #1;
        check("mid_out_valid", 64'(a_out_valid), 64'(0));
        check("mid_out_data",  64'(a_out_data),  64'(0));
        check("mid_in_ready",  64'(a_in_ready),  64'(1));
        check("mid_occ",       64'(a_occ),       64'(0));
        tick();
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        base_cnt = a_out_cnt;
        a_in_valid = 1'b1;
        a_in_data  = 32'hA1A1A1A1;
        tick();
        a_in_data  = 32'hA2A2A2A2;
        tick();
        a_in_valid = 1'b0;
        repeat (5) tick();
        check("mid_new_words", 64'(a_out_cnt - base_cnt), 64'(2));

`ifdef STREAM_SKID_PIPE_PARITY_EN
        check("par_clean", 64'(a_perr), 64'(0));
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h0F0F0F0F;
        tick();
        a_in_valid = 1'b0;
        repeat (2) tick();
        sb_hold = 1'b1;
        force dut_a.out_data = 32'h0F0F0F0E;
        a_out_ready = 1'b1;
        tick();
        release dut_a.out_data;
        sb_hold = 1'b0;
        check("par_err_set", 64'(a_perr), 64'(1));
        repeat (5) tick();
        check("par_err_sticky", 64'(a_perr), 64'(1));
        rst_n = 1'b0;
        #1;
        check("par_err_reset", 64'(a_perr), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_skid_pipe.md
# stream_skid_pipe

Parameterised valid/ready pipeline that registers a multi-lane data stream through a configurable number of stages. It sits directly downstream of the lane-generation stage: it takes the per-lane words produced by the generate-for lane logic and retimes them toward the consumer. Stage count and stage style are chosen at elaboration through labelled generate `if`/`for`/`case` blocks. Each stage either breaks only the forward path or breaks both the forward and backward paths.

## Interface
- `LANES`, 4, number of data lanes (≥1)
- `WIDTH`, 8, bits per lane (≥1)
- `STAGES`, 2, pipeline depth (0 = combinational passthrough)
- `MODE`, 1, stage style: 0 = forward register slice, 1 = full skid buffer
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  pipe accepts word
- `in_data`  in  LANES×WIDTH  packed lanes, lane 0 in the LSBs
- `out_valid`  out  1  downstream word valid
- `out_ready`  in  1  downstream accepts word
- `out_data`  out  LANES×WIDTH  packed lanes
- `occupancy`  out  $clog2(2·STAGES+1)  words currently held; minimum width 1

## Operation
- A transfer occurs on a clock edge where valid && ready.
- Words leave in arrival order. None are dropped or duplicated. Lane positions are preserved.
- `STAGES==0`: `out_*` = `in_*` and `in_ready` = `out_ready`, all combinational. `occupancy` = 0.
- `MODE 0` stage: holds one word. `ready_up` = !full || `ready_dn` (combinational path). Capacity is 1.
- `MODE 1` stage: FSM with states EMPTY, ONE, TWO.
  - EMPTY → ONE on upstream push.
  - ONE → TWO on push without pop.
  - ONE → EMPTY on pop without push.
  - TWO → ONE on pop.
  - ONE with simultaneous push and pop stays ONE and replaces the data.
  - `ready_up` = (state != TWO), driven from a flop with no combinational path from `ready_dn`.
  - The skid entry drains before the main entry is refilled.
  - Capacity is 2.
- `occupancy`: sum of the entries held across all stages, updated every cycle.
- Reset, async assert: all stages go to EMPTY; `out_valid`=0, `out_data`=0, `in_ready`=1 (STAGES>0), `occupancy`=0.
  - Reset mid-stream discards every in-flight word. No partial word appears after release.
- Illegal `MODE` value: elaboration `$error` in the generate `case` default branch.

## Timing
- Latency when empty with `out_ready`=1:
  - `STAGES` cycles from the `in_valid` edge to `out_valid`.
  - Sustained throughput is 1 word/cycle in both modes.
- MODE 1 backpressure: deasserting `out_ready` stops `in_ready` no later than one cycle after the last stage reaches TWO. Every word accepted in that window is held in a skid entry.
- MODE 0: `in_ready` combinationally follows `out_ready` through every full stage.
- `occupancy` reflects the state after the current edge, with no lag.

## Configuration
- `STREAM_SKID_PIPE_PARITY_EN` defined:
  - Each stage stores one even-parity bit per lane, computed at the input.
  - Adds output `parity_err` (1 bit, reset 0). It is a registered flag that sets on any output transfer whose lane parity mismatches, and it is sticky until reset.
- Undefined: no parity storage and no `parity_err` port.

## Structure
- Package `stream_pipe_pkg`: enum `pipe_mode_e` {`PM_SLICE`=0, `PM_SKID`=1}, and the stage-state enum `skid_state_e` {`SK_EMPTY`, `SK_ONE`, `SK_TWO`}.
- Sub-module `stream_skid_stage` implements one stage, with `MODE` as its parameter.
- Top-level generate blocks, all lowercase-labelled:
  - `if`-block `gen_bypass` / `gen_pipe` selects the passthrough or the pipe.
  - `for`-block `gen_stage` instantiates the stages.
  - `case` on `MODE` sits inside the stage.

## Test plan
- Reset, then `in_valid`=1 with `in_data`=32'h04030201, `out_ready`=1, STAGES=2 → `out_valid` rises 2 cycles later with `out_data`=32'h04030201; `occupancy` reads 1, 2, then 1.
- MODE 1, STAGES=2, `out_ready`=0, continuous input 1, 2, 3, … → exactly 4 words are accepted, `in_ready`=0, `occupancy`=4; after releasing `out_ready`, the output is 1, 2, 3, 4 in order with no gaps.
- MODE 0, STAGES=3, random `out_ready` toggling at 50% over 1000 words → scoreboard shows in-order, lossless delivery, and `in_ready` equals the combinational expectation every cycle.
- STAGES=0 → `out_data` equals `in_data` and `in_ready` equals `out_ready` in the same cycle; `occupancy`=0.
- Assert `rst_n` while `occupancy`=3 → all outputs are at reset values immediately (asynchronously); after release, only newly pushed words appear.
- With `STREAM_SKID_PIPE_PARITY_EN`, force one stored lane bit → `parity_err`=1 on that word's output transfer and stays 1 until reset.
